// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch FSM state encoding, default bus widths
// and the instruction word loaded into IR on reset.
package proc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Reset value of the instruction register; kept as a named constant so a
  // nonzero NOP encoding can be introduced without touching the fetch stage.
  localparam logic [DATA_W_DEF-1:0] NOP_INSTR = '0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC input and flush, instruction memory read port and the
// IR valid/ready handshake towards decode. The master modport is the fetch
// stage itself; the slave modport is the surrounding PC/memory/decode logic.
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] pc_in;
  logic              flush;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;
  logic              inc_pc;
  logic              fetch_fault;

  modport master (
    input  pc_in, flush, mem_valid, mem_data, ir_ready,
    output mem_rd, mem_addr, ir_out, ir_valid, inc_pc, fetch_fault
  );

  modport slave (
    output pc_in, flush, mem_valid, mem_data, ir_ready,
    input  mem_rd, mem_addr, ir_out, ir_valid, inc_pc, fetch_fault
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Issues one memory read per instruction at the
// current PC, captures the returned word into IR, offers it to decode with
// valid/ready and pulses inc_pc once per captured word. A flush (PC parallel
// load) discards any held or in-flight instruction.
// Optional build macro FETCH_TIMEOUT_EN: adds a memory wait timeout that sets
// a sticky fetch_fault and halts fetching until reset.
module instr_fetch
  import proc_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clock,
  input logic           reset,
  instr_fetch_if.master bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("instr_fetch: TIMEOUT_CYCLES must be at least 2");
  end

  fetch_state_t      state;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q;
  logic              inc_pc_q;

  logic              timeout_hit;  // memory wait limit reached this cycle
  logic              halted;       // fetch stopped by a timeout fault

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             fault_q;
  logic             waiting;

  assign waiting = (state == WAIT) || (state == DRAIN);

  // A flush in WAIT takes precedence over an expiring timeout; the count
  // carries on into DRAIN so the fault still fires on the next cycle.
  assign timeout_hit = waiting && !bus.mem_valid
                       && !((state == WAIT) && bus.flush)
                       && (wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared as a request issues, saturating count of cycles
  // spent waiting on memory.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == REQ) begin
      wait_cnt <= '0;
    end else if (waiting && (wait_cnt < CNT_W'(TIMEOUT_CYCLES))) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky fault flag: only reset clears it, flush leaves it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (timeout_hit) begin
      fault_q <= 1'b1;
    end
  end

  assign halted          = fault_q;
  assign bus.fetch_fault = fault_q;
`else
  assign timeout_hit     = 1'b0;
  assign halted          = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  // Fetch FSM with registered outputs: request, capture, hold for decode,
  // and drain of reads made stale by a flush.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: every output is a flop cleared by the async reset, so decode and
    // memory never see a glitch or an undefined request after reset.
    if (reset) begin
      state      <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= DATA_W'(NOP_INSTR);
      ir_valid_q <= 1'b0;
      inc_pc_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below turn
      // mem_rd and inc_pc into single-cycle pulses unless a state re-asserts.
      mem_rd_q <= 1'b0;
      inc_pc_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!halted) begin
            state <= REQ;
          end
        end
        REQ: begin
          // The request goes out even when flushed; its reply is drained.
          mem_rd_q   <= 1'b1;
          mem_addr_q <= bus.pc_in;
          state      <= bus.flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (bus.flush) begin
            state <= bus.mem_valid ? REQ : DRAIN;
          end else if (bus.mem_valid) begin
            ir_q       <= bus.mem_data;
            ir_valid_q <= 1'b1;
            inc_pc_q   <= 1'b1;
            state      <= HOLD;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (bus.flush || bus.ir_ready) begin
            ir_valid_q <= 1'b0;
            state      <= REQ;
          end
        end
        DRAIN: begin
          if (bus.mem_valid) begin
            state <= REQ;
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ir_out   = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.inc_pc   = inc_pc_q;

endmodule
